// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetches a 30-bit instruction as four byte reads from a byte-wide
//            program memory, with a single-entry last-fetch buffer.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int BUF_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_instr_addr,
    input  logic        i_instr_read,
    output logic [29:0] o_instr_data,
    output logic        o_instr_read_done,
    input  logic        i_flush,
    output logic [17:0] o_mem_addr,
    output logic        o_mem_read,
    input  logic [7:0]  i_mem_data,
    input  logic        i_mem_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic c_BUF_ON = (BUF_EN != 0);

    state_t      state_q;
    logic [1:0]  k_q;
    logic [15:0] addr_q;
    logic [15:0] tag_q;
    logic        bvalid_q;
    logic        flushed_q;
    logic [29:0] data_q;
    logic        done_q;
    logic        mread_q;
    logic [17:0] maddr_q;

    logic        w_hit;
    logic        unused_mem_hi;

    // A flush in the acceptance cycle wins over a tag match.
    assign w_hit = c_BUF_ON && bvalid_q && (tag_q == i_instr_addr) && !i_flush;

    // Top two bits of the final byte fall outside the 30-bit word.
    assign unused_mem_hi = ^i_mem_data[7:6];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            addr_q    <= 16'd0;
            tag_q     <= 16'd0;
            bvalid_q  <= 1'b0;
            flushed_q <= 1'b0;
            data_q    <= 30'd0;
            done_q    <= 1'b0;
            mread_q   <= 1'b0;
            maddr_q   <= 18'd0;
        end else begin
            mread_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_flush) begin
                flushed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_instr_read) begin
                        addr_q <= i_instr_addr;
                        if (w_hit) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            k_q       <= 2'd0;
                            flushed_q <= i_flush;
                            maddr_q   <= {i_instr_addr, 2'b00};
                            mread_q   <= 1'b1;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mem_valid) begin
                        case (k_q)
                            2'd0:    data_q[7:0]   <= i_mem_data;
                            2'd1:    data_q[15:8]  <= i_mem_data;
                            2'd2:    data_q[23:16] <= i_mem_data;
                            default: data_q[29:24] <= i_mem_data[5:0];
                        endcase
                        if (k_q != 2'd3) begin
                            k_q     <= k_q + 2'd1;
                            maddr_q <= {addr_q, k_q + 2'd1};
                            mread_q <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                            // Data fetched across a flush may be stale; deliver it but do not cache it.
                            if (!flushed_q && !i_flush) begin
                                tag_q    <= addr_q;
                                bvalid_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (i_flush) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign o_instr_data      = data_q;
    assign o_instr_read_done = done_q;
    assign o_mem_addr        = maddr_q;
    assign o_mem_read        = mread_q;

endmodule
`default_nettype wire
